// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core front end: fetch state encodings,
// PC width and reset vector.
package risc_pkg;

    localparam int PC_WIDTH   = 16;
    localparam int INST_WIDTH = 16;
    localparam logic [PC_WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        DISCARD = 3'd3,
        FAULT   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive ack-less cycles of an outstanding instruction read and flags
// the cycle in which the limit is reached. Only instantiated under FETCH_TIMEOUT_EN.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_clear,
    input  logic I_active,
    input  logic I_ack,
    output logic O_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear on (re)entry to a waiting state, otherwise count cycles without ack
    always_comb begin
        count_d = count_q;
        if (I_clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (I_active && !I_ack) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // The current cycle is the TIMEOUT_CYCLES-th one without ack
    assign O_expired = I_active && !I_ack && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// holds each word for the decoder. Optional read timeout under FETCH_TIMEOUT_EN.
module inst_fetch #(
    parameter int PC_WIDTH = risc_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = risc_pkg::RESET_PC
`ifdef FETCH_TIMEOUT_EN
    ,parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                            I_clk,
    input  logic                            I_rst,
    input  logic                            I_en,
    input  logic                            I_mem_ack,
    input  logic [risc_pkg::INST_WIDTH-1:0] I_mem_rdata,
    input  logic                            I_dec_ready,
    input  logic                            I_branch_en,
    input  logic [PC_WIDTH-1:0]             I_branch_target,
    output logic                            O_mem_req,
    output logic [PC_WIDTH-1:0]             O_mem_addr,
    output logic [risc_pkg::INST_WIDTH-1:0] O_inst,
    output logic                            O_inst_valid,
    output logic [PC_WIDTH-1:0]             O_pc,
    output logic                            O_fault
);

    import risc_pkg::*;

    fetch_state_e            state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic                    mem_req_q, mem_req_d;
    logic [PC_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic                    inst_valid_q, inst_valid_d;
    logic [PC_WIDTH-1:0]     out_pc_q, out_pc_d;
    logic                    fault_q, fault_d;
    logic [PC_WIDTH-1:0]     redirect_pc_s;
    logic                    expired_s;

    assign redirect_pc_s = I_branch_en ? I_branch_target : pc_q;

    // Next-state, PC and registered-output logic; a branch always overrides the PC
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        out_pc_d     = out_pc_q;
        fault_d      = fault_q;
        case (state_q)
            IDLE: begin
                pc_d = redirect_pc_s;
                if (I_en) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc_s;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (I_branch_en || I_dec_ready) begin
                    pc_d         = redirect_pc_s;
                    inst_valid_d = 1'b0;
                    if (I_en) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = redirect_pc_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            REQ: begin
                if (I_mem_ack && I_branch_en) begin
                    pc_d       = I_branch_target;
                    mem_addr_d = I_branch_target;
                    state_d    = REQ;
                end else if (I_mem_ack) begin
                    inst_d       = I_mem_rdata;
                    out_pc_d     = mem_addr_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + PC_WIDTH'(1);
                    mem_req_d    = 1'b0;
                    state_d      = HOLD;
                end else if (expired_s) begin
                    fault_d      = 1'b1;
                    mem_req_d    = 1'b0;
                    inst_valid_d = 1'b0;
                    state_d      = FAULT;
                end else if (I_branch_en) begin
                    pc_d    = I_branch_target;
                    state_d = DISCARD;
                end else begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                // A branch arriving together with the stale ack still retires the discard
                pc_d = redirect_pc_s;
                if (I_mem_ack) begin
                    if (I_en) begin
                        state_d    = REQ;
                        mem_addr_d = redirect_pc_s;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (expired_s) begin
                    fault_d      = 1'b1;
                    mem_req_d    = 1'b0;
                    inst_valid_d = 1'b0;
                    state_d      = FAULT;
                end else begin
                    state_d = DISCARD;
                end
            end
            FAULT: begin
                state_d      = FAULT;
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    logic wd_clear_s;
    logic wd_active_s;

    assign wd_clear_s  = ((state_d == REQ) && ((state_q != REQ) || I_mem_ack))
                       || ((state_d == DISCARD) && (state_q != DISCARD));
    assign wd_active_s = (state_q == REQ) || (state_q == DISCARD);

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_clear   (wd_clear_s),
        .I_active  (wd_active_s),
        .I_ack     (I_mem_ack),
        .O_expired (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // State, PC and output registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= RESET_PC;
            inst_q       <= {INST_WIDTH{1'b0}};
            inst_valid_q <= 1'b0;
            out_pc_q     <= {PC_WIDTH{1'b0}};
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            out_pc_q     <= out_pc_d;
            fault_q      <= fault_d;
        end
    end

    assign O_mem_req    = mem_req_q;
    assign O_mem_addr   = mem_addr_q;
    assign O_inst       = inst_q;
    assign O_inst_valid = inst_valid_q;
    assign O_pc         = out_pc_q;
    assign O_fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed cycle-by-cycle bench for inst_fetch: a vector table for the main
// fetch/branch/stall paths plus hand-written timeout and async-reset sequences.
module tb_inst_fetch;

    typedef struct {
        logic        en;
        logic        ack;
        logic [15:0] rdata;
        logic        rdy;
        logic        br;
        logic [15:0] tgt;
        logic        req;
        logic [15:0] addr;
        logic [15:0] inst;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    localparam int NVEC = 31;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic        ack   = 1'b0;
    logic [15:0] rdata = 16'h0000;
    logic        rdy   = 1'b0;
    logic        br    = 1'b0;
    logic [15:0] tgt   = 16'h0000;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs [NVEC];

    inst_fetch dut (
        .I_clk           (clk),
        .I_rst           (rst),
        .I_en            (en),
        .I_mem_ack       (ack),
        .I_mem_rdata     (rdata),
        .I_dec_ready     (rdy),
        .I_branch_en     (br),
        .I_branch_target (tgt),
        .O_mem_req       (mem_req),
        .O_mem_addr      (mem_addr),
        .O_inst          (inst),
        .O_inst_valid    (inst_valid),
        .O_pc            (pc),
        .O_fault         (fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic i_en, input logic i_ack, input logic [15:0] i_rdata,
                                input logic i_rdy, input logic i_br, input logic [15:0] i_tgt,
                                input logic e_req, input logic [15:0] e_addr, input logic [15:0] e_inst,
                                input logic e_valid, input logic [15:0] e_pc);
        vec_t v;
        v.en = i_en;   v.ack = i_ack;   v.rdata = i_rdata;
        v.rdy = i_rdy; v.br = i_br;     v.tgt = i_tgt;
        v.req = e_req; v.addr = e_addr; v.inst = e_inst;
        v.valid = e_valid; v.pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic e_req, input logic [15:0] e_addr,
                             input logic [15:0] e_inst, input logic e_valid,
                             input logic [15:0] e_pc, input logic e_fault);
        check("mem_req",    idx, {15'd0, mem_req},    {15'd0, e_req});
        check("mem_addr",   idx, mem_addr,            e_addr);
        check("inst",       idx, inst,                e_inst);
        check("inst_valid", idx, {15'd0, inst_valid}, {15'd0, e_valid});
        check("pc",         idx, pc,                  e_pc);
        check("fault",      idx, {15'd0, fault},      {15'd0, e_fault});
    endtask

    task automatic drive(input logic i_en, input logic i_ack, input logic [15:0] i_rdata,
                         input logic i_rdy, input logic i_br, input logic [15:0] i_tgt);
        en = i_en; ack = i_ack; rdata = i_rdata; rdy = i_rdy; br = i_br; tgt = i_tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              en  ack   rdata    rdy br  tgt        req addr     inst     vld pc
        vecs[0]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,16'h0000,1'b0,16'h0000);
        vecs[1]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,16'h0000,1'b0,16'h0000);
        vecs[2]  = mk(1'b1,1'b1,16'h1234,1'b1,1'b0,16'h0000, 1'b0,16'h0000,16'h1234,1'b1,16'h0000);
        vecs[3]  = mk(1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,16'h0001,16'h1234,1'b0,16'h0000);
        vecs[4]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0001,16'h1234,1'b0,16'h0000);
        vecs[5]  = mk(1'b1,1'b1,16'hABCD,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hABCD,1'b1,16'h0001);
        vecs[6]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hABCD,1'b1,16'h0001);
        vecs[7]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hABCD,1'b1,16'h0001);
        vecs[8]  = mk(1'b1,1'b1,16'hFFFF,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hABCD,1'b1,16'h0001);
        vecs[9]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hABCD,1'b1,16'h0001);
        vecs[10] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0001,16'hABCD,1'b1,16'h0001);
        vecs[11] = mk(1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,16'h0002,16'hABCD,1'b0,16'h0001);
        vecs[12] = mk(1'b1,1'b1,16'h5555,1'b0,1'b0,16'h0000, 1'b0,16'h0002,16'h5555,1'b1,16'h0002);
        vecs[13] = mk(1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,16'h0003,16'h5555,1'b0,16'h0002);
        vecs[14] = mk(1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0040, 1'b1,16'h0003,16'h5555,1'b0,16'h0002);
        vecs[15] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0003,16'h5555,1'b0,16'h0002);
        vecs[16] = mk(1'b1,1'b1,16'hBEEF,1'b0,1'b0,16'h0000, 1'b1,16'h0040,16'h5555,1'b0,16'h0002);
        vecs[17] = mk(1'b1,1'b1,16'h7777,1'b0,1'b1,16'h0100, 1'b1,16'h0100,16'h5555,1'b0,16'h0002);
        vecs[18] = mk(1'b1,1'b1,16'h8888,1'b0,1'b0,16'h0000, 1'b0,16'h0100,16'h8888,1'b1,16'h0100);
        vecs[19] = mk(1'b1,1'b0,16'h0000,1'b1,1'b1,16'hFFFF, 1'b1,16'hFFFF,16'h8888,1'b0,16'h0100);
        vecs[20] = mk(1'b1,1'b1,16'hCAFE,1'b0,1'b0,16'h0000, 1'b0,16'hFFFF,16'hCAFE,1'b1,16'hFFFF);
        vecs[21] = mk(1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,16'h0000,16'hCAFE,1'b0,16'hFFFF);
        vecs[22] = mk(1'b0,1'b1,16'h0F0F,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0F0F,1'b1,16'h0000);
        vecs[23] = mk(1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0000,16'h0F0F,1'b0,16'h0000);
        vecs[24] = mk(1'b0,1'b1,16'hDEAD,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0F0F,1'b0,16'h0000);
        vecs[25] = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0200, 1'b0,16'h0000,16'h0F0F,1'b0,16'h0000);
        vecs[26] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0200,16'h0F0F,1'b0,16'h0000);
        vecs[27] = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0300, 1'b1,16'h0200,16'h0F0F,1'b0,16'h0000);
        vecs[28] = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0400, 1'b1,16'h0200,16'h0F0F,1'b0,16'h0000);
        vecs[29] = mk(1'b0,1'b1,16'h1111,1'b0,1'b0,16'h0000, 1'b0,16'h0200,16'h0F0F,1'b0,16'h0000);
        vecs[30] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0400,16'h0F0F,1'b0,16'h0000);

        // Reset values while reset is held
        repeat (2) step();
        check_all(100, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
            step();
            check_all(i, vecs[i].req, vecs[i].addr, vecs[i].inst, vecs[i].valid, vecs[i].pc, 1'b0);
        end

        // Outstanding read at 0x0400 with no ack: 14 cycles never time out
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        repeat (14) step();
        check_all(200, 1'b1, 16'h0400, 16'h0F0F, 1'b0, 16'h0000, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        step();
        check_all(201, 1'b0, 16'h0400, 16'h0F0F, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 1'b1, 16'h9999, 1'b1, 1'b1, 16'h1234);
        repeat (3) step();
        check_all(202, 1'b0, 16'h0400, 16'h0F0F, 1'b0, 16'h0000, 1'b1);
`else
        repeat (26) step();
        check_all(201, 1'b1, 16'h0400, 16'h0F0F, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 1'b1, 16'h4242, 1'b0, 1'b0, 16'h0000);
        step();
        check_all(202, 1'b0, 16'h0400, 16'h4242, 1'b1, 16'h0400, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        step();
        check_all(203, 1'b1, 16'h0401, 16'h4242, 1'b0, 16'h0400, 1'b0);
`endif

        // Asynchronous reset between clock edges clears everything at once
        rst = 1'b1;
        #2;
        check_all(300, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step();
        check_all(301, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage of the 16-bit RISC core; sits directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction, with its PC, to the decoder until the decoder accepts it.
- Handles branch redirects, including discarding a read already in flight.

Parameters:
- PC_WIDTH, 16, width of PC and memory address (word-addressed).
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, cycles without ack before fault; used only with FETCH_TIMEOUT_EN.

Ports:
- I_clk  in  1  clock; all state updates on rising edge.
- I_rst  in  1  reset, asynchronous, active-high.
- I_en  in  1  fetch enable; low blocks new requests (global stall).
- I_mem_ack  in  1  single-cycle read completion from instruction memory.
- I_mem_rdata  in  16  read data, valid when I_mem_ack=1.
- I_dec_ready  in  1  decoder accepts O_inst this cycle.
- I_branch_en  in  1  redirect request.
- I_branch_target  in  PC_WIDTH  redirect address.
- O_mem_req  out  1  read request; held high until ack.
- O_mem_addr  out  PC_WIDTH  read address; stable while O_mem_req=1.
- O_inst  out  16  fetched instruction.
- O_inst_valid  out  1  O_inst/O_pc valid.
- O_pc  out  PC_WIDTH  address of O_inst.
- O_fault  out  1  sticky fetch timeout (0 when feature absent).

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC. O_mem_req=0, O_mem_addr=RESET_PC, O_inst=0, O_inst_valid=0, O_pc=0, O_fault=0. Reset mid-request drops O_mem_req immediately; memory must tolerate abandoned reads.
- All outputs are registered and change only on the rising edge, so O_inst is stable across the decoder's falling-edge sample.
- States: IDLE, REQ, HOLD, DISCARD, FAULT (FAULT only with the feature).
- IDLE: if I_en=1, next cycle enter REQ with O_mem_req=1 and O_mem_addr=PC.
- REQ, on I_mem_ack:
  - O_inst<=I_mem_rdata, O_pc<=O_mem_addr, O_inst_valid<=1, PC<=PC+1, O_mem_req<=0, go to HOLD.
  - PC+1 wraps from 16'hFFFF to 16'h0000.
  - I_en=0 does not abort a REQ in progress.
- HOLD: on I_dec_ready=1, O_inst_valid<=0 next cycle. Then go to REQ (new address PC) if I_en=1, else IDLE.
- Throughput: minimum 3 cycles per instruction with a 1-cycle memory.
- Branch (I_branch_en=1) has highest priority:
  - In IDLE or HOLD: PC<=target, O_inst_valid<=0, then REQ if I_en=1, else IDLE. A simultaneous I_dec_ready is ignored; the instruction is squashed.
  - In REQ without ack: PC<=target, go to DISCARD. O_mem_req and O_mem_addr stay unchanged until the ack arrives.
  - In REQ with ack in the same cycle: data dropped, O_inst_valid stays 0, PC<=target, go to REQ at target.
  - In DISCARD: PC<=target (latest branch wins), remain in DISCARD.
- DISCARD: on I_mem_ack, drop the data and go to REQ (if I_en=1) or IDLE with PC unchanged.
- I_mem_ack outside REQ or DISCARD is ignored.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit-or-wider cycle counter clears on entry to REQ or DISCARD and increments each cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: O_fault<=1 (sticky), O_mem_req<=0, O_inst_valid<=0, state FAULT.
  - FAULT is left only by reset.
- Undefined: O_fault tied 0, no counter, waits indefinitely for ack.

Decomposition:
- Shared package risc_pkg holds:
  - state encodings (3-bit localparams IDLE/REQ/HOLD/DISCARD/FAULT);
  - PC_WIDTH;
  - RESET_PC default.
- One natural sub-module: fetch_watchdog (counter plus compare, compiled only under FETCH_TIMEOUT_EN).
- PC and handshake logic stay in inst_fetch.

Test Plan:
- Reset, I_en=1, memory acks 1 cycle after req with 16'h1234, I_dec_ready=1 → O_mem_addr=0000, then O_inst=1234, O_pc=0000, valid for 1 cycle; next O_mem_addr=0001.
- Decoder stall: I_dec_ready=0 for 5 cycles → O_inst_valid and O_inst held stable, O_mem_req=0 throughout.
- Branch to 16'h0040 while REQ pending at 0003, ack 2 cycles later with 16'hBEEF → BEEF never valid; next O_mem_addr=0040.
- Branch coinciding with ack → data dropped, next request at target, PC of dropped word not recorded.
- PC=16'hFFFF fetched → O_pc=FFFF, next O_mem_addr=0000.
- With FETCH_TIMEOUT_EN, no ack for 15 cycles → O_fault=1, O_mem_req=0, stays until I_rst; without macro → O_mem_req held high indefinitely, O_fault=0.
